// File: rtl/int_div_ctrl.sv
// Request controller in front of the combinational int_div stage; traps divide-by-zero locally.
// Latency: result valid SETTLE cycles after accept (next cycle for divide-by-zero).
// Backpressure: holds result and deasserts in_ready until out_ready retires it.
module int_div_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_dividend,
    input  logic [7:0]  in_divisor,
    output logic [7:0]  div_dividend,
    output logic [7:0]  div_divisor,
    input  logic [11:0] div_quotient,
    input  logic [7:0]  div_remainder,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_quotient,
    output logic [7:0]  out_remainder,
    output logic        out_dz,
    output logic        busy
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [7:0]  r_div_dividend;
    logic [7:0]  r_div_divisor;
    logic [11:0] r_out_quotient;
    logic [7:0]  r_out_remainder;
    logic        r_out_dz;

    logic        w_accept;
    logic        w_dz_req;
    logic        w_capture;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_dz_req  = (in_divisor == 8'd0);
    assign w_capture = (r_state == ST_WAIT) && (r_cnt == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_dz_req ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Retiring edge never accepts; the next request waits for IDLE.
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Zero divisors never reach the operand registers, so int_div stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= 4'd0;
            r_div_dividend  <= 8'd0;
            r_div_divisor   <= 8'd0;
            r_out_quotient  <= 12'd0;
            r_out_remainder <= 8'd0;
            r_out_dz        <= 1'b0;
        end else begin
            if (w_accept && !w_dz_req) begin
                r_div_dividend <= in_dividend;
                r_div_divisor  <= in_divisor;
                r_cnt          <= LP_SETTLE;
            end
            if (w_accept && w_dz_req) begin
                r_out_quotient  <= 12'hFFF;
                r_out_remainder <= in_dividend;
                r_out_dz        <= 1'b1;
            end
            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_out_quotient  <= div_quotient;
                r_out_remainder <= div_remainder;
                r_out_dz        <= 1'b0;
            end
        end
    end

    assign in_ready      = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign out_valid     = (r_state == ST_DONE);
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;
    assign out_quotient  = r_out_quotient;
    assign out_remainder = r_out_remainder;
    assign out_dz        = r_out_dz;

endmodule

// File: tb/tb_int_div_ctrl.sv
// Bench for int_div_ctrl: SETTLE=2 instance with a behavioural int_div attached,
// SETTLE=3 instance with a stepping stub divider.
module tb_int_div_ctrl;

    localparam int S_A = 2;
    localparam int S_B = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Instance A signals
    logic        in_valid, in_ready, out_valid, out_ready, out_dz, busy;
    logic [7:0]  in_dividend, in_divisor, div_dividend, div_divisor, div_remainder, out_remainder;
    logic [11:0] div_quotient, out_quotient;
    // Instance B signals
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_dz_b, busy_b;
    logic [7:0]  in_dividend_b, in_divisor_b, div_dividend_b, div_divisor_b, div_remainder_b, out_remainder_b;
    logic [11:0] div_quotient_b, out_quotient_b;

    // Behavioural int_div: Q8.4 quotient truncated toward zero, remainder takes dividend sign.
    function automatic logic [11:0] int_div_q(input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int q;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return 12'd0;
        q = (sa * 16) / sb;
        return q[11:0];
    endfunction

    function automatic logic [7:0] int_div_r(input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return 8'd0;
        r = sa % sb;
        return r[7:0];
    endfunction

    assign div_quotient  = int_div_q(div_dividend, div_divisor);
    assign div_remainder = int_div_r(div_dividend, div_divisor);

    logic [11:0] stub_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          stub_q <= 12'd0;
        else if (in_valid_b && in_ready_b)   stub_q <= 12'd1;
        else                                 stub_q <= stub_q + 12'd1;
    end
    assign div_quotient_b  = stub_q;
    assign div_remainder_b = stub_q[7:0] + 8'h10;

    int_div_ctrl #(.SETTLE(S_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dz(out_dz), .busy(busy)
    );

    int_div_ctrl #(.SETTLE(S_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_dividend(in_dividend_b), .in_divisor(in_divisor_b),
        .div_dividend(div_dividend_b), .div_divisor(div_divisor_b),
        .div_quotient(div_quotient_b), .div_remainder(div_remainder_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_quotient(out_quotient_b), .out_remainder(out_remainder_b),
        .out_dz(out_dz_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] exp_q;
        logic [7:0]  exp_r;
        logic        exp_dz;
        int          waited;
        int          lat;
        int          acc;
        int          prev_acc;
        int          prev_gap;
        int          pulses;

        rst_n = 1'b0;
        in_valid = 1'b0; in_dividend = 8'd0; in_divisor = 8'd0; out_ready = 1'b0;
        in_valid_b = 1'b0; in_dividend_b = 8'd0; in_divisor_b = 8'd0; out_ready_b = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_q", out_quotient, 0);
        check("rst_out_r", out_remainder, 0);
        check("rst_out_dz", out_dz, 0);
        check("rst_div_dvd", div_dividend, 0);
        check("rst_div_dvs", div_divisor, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Positive divide 100/7
        in_valid = 1'b1; in_dividend = 8'd100; in_divisor = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("pos_busy", busy, 1);
        check("pos_div_dvd", div_dividend, 100);
        check("pos_div_dvs", div_divisor, 7);
        check("pos_valid_t0", out_valid, 0);
        @(negedge clk);
        check("pos_valid_t1", out_valid, 0);
        @(negedge clk);
        check("pos_valid_t2", out_valid, 1);
        check("pos_q", out_quotient, 12'h0E4);
        check("pos_r", out_remainder, 8'd2);
        check("pos_dz", out_dz, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("pos_retired", out_valid, 0);
        check("pos_hold_q", out_quotient, 12'h0E4);
        out_ready = 1'b0;

        // Divide-by-zero
        in_valid = 1'b1; in_dividend = 8'd25; in_divisor = 8'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check("dz_valid", out_valid, 1);
        check("dz_q", out_quotient, 12'hFFF);
        check("dz_r", out_remainder, 8'd25);
        check("dz_flag", out_dz, 1);
        check("dz_div_dvs_kept", div_divisor, 7);
        out_ready = 1'b1;
        @(negedge clk);
        check("dz_retired", out_valid, 0);
        out_ready = 1'b0;

        // Settle window on the SETTLE=3 instance with stepping stub
        in_valid_b = 1'b1; in_dividend_b = 8'd50; in_divisor_b = 8'd3;
        @(negedge clk);
        in_valid_b = 1'b0;
        for (int k = 0; k < S_B; k++) begin
            check("settle_valid_early", out_valid_b, 0);
            check("settle_div_dvd", div_dividend_b, 50);
            check("settle_div_dvs", div_divisor_b, 3);
            @(negedge clk);
        end
        check("settle_valid", out_valid_b, 1);
        check("settle_q", out_quotient_b, 12'd3);
        check("settle_r", out_remainder_b, 8'h13);
        check("settle_dz", out_dz_b, 0);
        check("settle_div_dvd_end", div_dividend_b, 50);
        out_ready_b = 1'b1;
        @(negedge clk);
        check("settle_retired", out_valid_b, 0);
        check("settle_idle", busy_b, 0);

        // Backpressure: result held 5 cycles while a second request waits
        in_valid = 1'b1; in_dividend = 8'hCE; in_divisor = 8'd6;
        @(negedge clk);
        in_dividend = 8'h9C; in_divisor = 8'hF7;
        check("bp_busy", busy, 1);
        repeat (S_A) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_q", out_quotient, 12'hF7B);
            check("bp_r", out_remainder, 8'hFE);
            check("bp_dz", out_dz, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_retired", out_valid, 0);
        check("bp_not_taken", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_busy", busy, 1);
        check("bp_second_dvd", div_dividend, 8'h9C);
        check("bp_second_dvs", div_divisor, 8'hF7);
        repeat (S_A) @(negedge clk);
        check("bp_second_valid", out_valid, 1);
        check("bp_second_q", out_quotient, 12'h0B1);
        check("bp_second_r", out_remainder, 8'hFF);
        @(negedge clk);
        check("bp_second_retired", out_valid, 0);

        // Reset mid-WAIT
        in_valid = 1'b1; in_dividend = 8'd20; in_divisor = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check("rw_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rw_out_valid", out_valid, 0);
        check("rw_busy_rst", busy, 0);
        check("rw_in_ready", in_ready, 1);
        check("rw_out_q", out_quotient, 0);
        check("rw_out_r", out_remainder, 0);
        check("rw_div_dvd", div_dividend, 0);
        check("rw_div_dvs", div_divisor, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rw_no_pulse", pulses, 0);
        check("rw_idle", busy, 0);

        // Back-to-back random pairs, out_ready tied high
        out_ready = 1'b1;
        prev_acc = 0;
        prev_gap = 0;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            exp_dz = (b == 8'd0);
            exp_q  = exp_dz ? 12'hFFF : int_div_q(a, b);
            exp_r  = exp_dz ? a : int_div_r(a, b);
            in_valid = 1'b1; in_dividend = a; in_divisor = b;
            waited = 0;
            while (!in_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("b2b_accept_timeout", waited < 20, 1);
            @(negedge clk);
            acc = cyc;
            in_valid = 1'b0;
            if (i > 0) check("b2b_spacing", acc - prev_acc, prev_gap);
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("b2b_latency", lat, exp_dz ? 0 : S_A);
            check("b2b_q", out_quotient, exp_q);
            check("b2b_r", out_remainder, exp_r);
            check("b2b_dz", out_dz, exp_dz);
            prev_acc = acc;
            prev_gap = exp_dz ? 2 : S_A + 2;
        end
        @(negedge clk);
        check("b2b_drained", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
